physical_iob_tap_tracker: RTL

- Parametrised successor to the receiver's single-window IDELAY tap monitor.
- Runs continuous eye tracking on one LVDS lane by comparing master ISERDES data against monitor ISERDES data.
- Probes the monitor tap at the left and right edges of a programmable window. Mismatch counting over several samples against a threshold decides whether the master tap moves.
- Adds tap saturation detection with a sticky fail flag, a configurable monitor polarity, and a count of edge hits. Sits between the physical ISERDES pair and the IDELAY tap loaders.

---
 rtl/physical_iob_tap_tracker.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/physical_iob_tap_tracker.sv
// Continuous eye tracker for one LVDS lane: probes the monitor IDELAY tap at
// both window edges and nudges the master tap away from any edge that errors.
module physical_iob_tap_tracker #(
  parameter int unsigned SERDES_WIDTH    = 4,
  parameter int unsigned TAP_WIDTH       = 5,
  parameter int unsigned WAIT_COMP_WIDTH = 4,
  parameter int unsigned SAMPLE_WIDTH    = 3,
  parameter int unsigned ERR_THRESHOLD   = 1,
  parameter int unsigned MONITOR_INVERT  = 1,
  parameter int unsigned HIT_CNT_WIDTH   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_enable,
  input  logic [SERDES_WIDTH-1:0]  i_serdes_master,
  input  logic [SERDES_WIDTH-1:0]  i_serdes_monitor,
  input  logic [TAP_WIDTH-1:0]     i_init_delay_tabs,
  input  logic [TAP_WIDTH-1:0]     i_init_edge_tabs,
  output logic [TAP_WIDTH-1:0]     o_master_delay_tabs,
  output logic [TAP_WIDTH-1:0]     o_monitor_delay_tabs,
  output logic                     o_delay_tabs_update,
  output logic                     o_run,
  output logic                     o_fail,
  output logic [HIT_CNT_WIDTH-1:0] o_edge_hits
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT,
    S_SETTLE_L, S_SAMPLE_L, S_ADJ_L, S_MOVE_R,
    S_SETTLE_R, S_SAMPLE_R, S_ADJ_R, S_MOVE_L,
    S_FAIL
  } state_t;

  localparam int unsigned ERR_WIDTH = SAMPLE_WIDTH + 1;
  localparam logic [ERR_WIDTH-1:0] ERR_THR = ERR_WIDTH'(ERR_THRESHOLD);

  // Reset release synchroniser; assertion stays asynchronous.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) rst_sync_q <= '0;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic                    en_q;
  logic [SERDES_WIDTH-1:0] master_word_q;
  logic [SERDES_WIDTH-1:0] monitor_word_q;
  logic                    mismatch;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q           <= 1'b0;
      master_word_q  <= '0;
      monitor_word_q <= '0;
    end else begin
      en_q           <= i_enable;
      master_word_q  <= i_serdes_master;
      monitor_word_q <= (MONITOR_INVERT != 0) ? ~i_serdes_monitor : i_serdes_monitor;
    end
  end

  assign mismatch = (master_word_q != monitor_word_q);

  state_t                   state_q;
  logic [TAP_WIDTH-1:0]     master_q, master_d;
  logic [TAP_WIDTH-1:0]     monitor_q, monitor_d;
  logic [TAP_WIDTH-1:0]     window_q;
  logic [HIT_CNT_WIDTH-1:0] hits_q;
  logic [WAIT_COMP_WIDTH-1:0] wait_q;
  logic [SAMPLE_WIDTH-1:0]  samp_q;
  logic [ERR_WIDTH-1:0]     err_q;
  logic                     run_q, fail_q, update_q;

  logic [TAP_WIDTH-1:0]     half;
  logic [TAP_WIDTH:0]       left_w, right_w;
  logic                     adj_l_fail, adj_r_fail, edge_hit;
  logic [ERR_WIDTH-1:0]     err_next;
  logic [HIT_CNT_WIDTH-1:0] hits_inc;

  // Extra top bit of left_w/right_w is the borrow/carry: tap range exceeded.
  assign half       = window_q >> 1;
  assign left_w     = {1'b0, master_q} - {1'b0, half};
  assign right_w    = {1'b0, master_q} + {1'b0, half};
  assign adj_l_fail = (master_q == '1) || (monitor_q == '1);
  assign adj_r_fail = (master_q == '0) || (monitor_q == '0);
  assign err_next   = (mismatch && (err_q != '1)) ? err_q + 1'b1 : err_q;
  assign edge_hit   = (err_next >= ERR_THR);
  assign hits_inc   = (hits_q == '1) ? hits_q : hits_q + 1'b1;

  always_comb begin
    master_d  = master_q;
    monitor_d = monitor_q;
    case (state_q)
      S_IDLE: begin
        master_d  = i_init_delay_tabs;
        monitor_d = i_init_delay_tabs;
      end
      S_INIT:   if (!left_w[TAP_WIDTH]) monitor_d = left_w[TAP_WIDTH-1:0];
      S_MOVE_L: if (en_q && !left_w[TAP_WIDTH]) monitor_d = left_w[TAP_WIDTH-1:0];
      S_MOVE_R: if (en_q && !right_w[TAP_WIDTH]) monitor_d = right_w[TAP_WIDTH-1:0];
      S_ADJ_L: if (!adj_l_fail) begin
        master_d  = master_q + 1'b1;
        monitor_d = monitor_q + 1'b1;
      end
      S_ADJ_R: if (!adj_r_fail) begin
        master_d  = master_q - 1'b1;
        monitor_d = monitor_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      master_q  <= '0;
      monitor_q <= '0;
      window_q  <= '0;
      hits_q    <= '0;
      wait_q    <= '0;
      samp_q    <= '0;
      err_q     <= '0;
      run_q     <= 1'b0;
      fail_q    <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      master_q  <= master_d;
      monitor_q <= monitor_d;
      update_q  <= (master_d != master_q) || (monitor_d != monitor_q);
      run_q     <= (state_q != S_IDLE) && (state_q != S_FAIL);
      fail_q    <= (state_q == S_FAIL);
      case (state_q)
        S_IDLE: begin
          window_q <= i_init_edge_tabs;
          if (en_q) state_q <= S_INIT;
        end
        S_INIT: begin
          hits_q  <= '0;
          state_q <= left_w[TAP_WIDTH] ? S_FAIL : S_SETTLE_L;
        end
        S_SETTLE_L, S_SETTLE_R: begin
          if (wait_q == '1) begin
            wait_q  <= '0;
            samp_q  <= '0;
            err_q   <= '0;
            state_q <= (state_q == S_SETTLE_L) ? S_SAMPLE_L : S_SAMPLE_R;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_SAMPLE_L, S_SAMPLE_R: begin
          err_q  <= err_next;
          samp_q <= samp_q + 1'b1;
          if (samp_q == '1) begin
            if (state_q == S_SAMPLE_L) state_q <= edge_hit ? S_ADJ_L : S_MOVE_R;
            else                       state_q <= edge_hit ? S_ADJ_R : S_MOVE_L;
          end
        end
        S_ADJ_L: begin
          if (adj_l_fail) state_q <= S_FAIL;
          else begin
            hits_q  <= hits_inc;
            state_q <= S_SETTLE_L;
          end
        end
        S_ADJ_R: begin
          if (adj_r_fail) state_q <= S_FAIL;
          else begin
            hits_q  <= hits_inc;
            state_q <= S_SETTLE_R;
          end
        end
        S_MOVE_R: begin
          if (!en_q)                  state_q <= S_IDLE;
          else if (right_w[TAP_WIDTH]) state_q <= S_FAIL;
          else                        state_q <= S_SETTLE_R;
        end
        S_MOVE_L: begin
          if (!en_q)                  state_q <= S_IDLE;
          else if (left_w[TAP_WIDTH]) state_q <= S_FAIL;
          else                        state_q <= S_SETTLE_L;
        end
        S_FAIL:  if (!en_q) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_master_delay_tabs  = master_q;
  assign o_monitor_delay_tabs = monitor_q;
  assign o_delay_tabs_update  = update_q;
  assign o_run                = run_q;
  assign o_fail               = fail_q;
  assign o_edge_hits          = hits_q;

endmodule
